// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// FSM state type and small extension helpers.
package dmem_responder_pkg;

    // RV32I load encodings
    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    // RV32I store encodings
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the core (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid_in;
    logic        req_ready_out;
    logic        req_we_in;
    logic [31:0] req_addr_in;
    logic [2:0]  req_funct3_in;
    logic [31:0] req_wdata_in;
    logic        rsp_valid_out;
    logic        rsp_ready_in;
    logic [31:0] rsp_rdata_out;
    logic        rsp_err_out;

    modport master (
        output req_valid_in, req_we_in, req_addr_in, req_funct3_in, req_wdata_in, rsp_ready_in,
        input  req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out
    );

    modport slave (
        input  req_valid_in, req_we_in, req_addr_in, req_funct3_in, req_wdata_in, rsp_ready_in,
        output req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte-enables and replicated data,
// load lane extraction with sign/zero extension, and misalign/illegal flag.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] sdata_o,
    output logic [31:0] ldata_o,
    output logic        bad_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign shifted = rword_i >> {lane_i, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = lane_i[1] ? rword_i[31:16] : rword_i[15:0];

    // Decode access size into lane controls and alignment/legality checks
    always_comb begin
        be_o    = 4'b0000;
        sdata_o = 32'h0;
        ldata_o = 32'h0;
        bad_o   = 1'b0;
        if (we_i) begin
            case (funct3_i)
                FUNCT3_SB: begin
                    be_o    = 4'b0001 << lane_i;
                    sdata_o = {4{wdata_i[7:0]}};
                end
                FUNCT3_SH: begin
                    bad_o   = lane_i[0];
                    be_o    = 4'b0011 << lane_i;
                    sdata_o = {2{wdata_i[15:0]}};
                end
                FUNCT3_SW: begin
                    bad_o   = (lane_i != 2'b00);
                    be_o    = 4'b1111;
                    sdata_o = wdata_i;
                end
                default: bad_o = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                FUNCT3_LB:  ldata_o = sext8(byte_v);
                FUNCT3_LBU: ldata_o = {24'h0, byte_v};
                FUNCT3_LH: begin
                    bad_o   = lane_i[0];
                    ldata_o = sext16(half_v);
                end
                FUNCT3_LHU: begin
                    bad_o   = lane_i[0];
                    ldata_o = {16'h0, half_v};
                end
                FUNCT3_LW: begin
                    bad_o   = (lane_i != 2'b00);
                    ldata_o = rword_i;
                end
                default: bad_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time over a
// valid/ready handshake, waits LATENCY cycles, performs the RAM access and
// holds a registered response until the core takes it.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic           clk_in,
    input logic           rst_in,
    dmem_responder_if.slave dmem
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  LOAD_CNT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] mem [0:DEPTH_WORDS-1];

    logic             accept;
    logic             exec;
    logic             cur_we;
    logic [31:0]      cur_addr;
    logic [2:0]       cur_funct3;
    logic [31:0]      cur_wdata;
    logic [31:0]      offset;
    logic             range_err;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rword;
    logic [3:0]       be;
    logic [31:0]      sdata;
    logic [31:0]      ldata;
    logic             lane_bad;
    logic             acc_err;
    logic [31:0]      rdata_d;

    assign dmem.req_ready_out = (state_q == ST_IDLE) && !rst_in;
    assign dmem.rsp_valid_out = rsp_valid_q;
    assign dmem.rsp_rdata_out = rsp_rdata_q;
    assign dmem.rsp_err_out   = rsp_err_q;

    assign accept = dmem.req_valid_in && dmem.req_ready_out;

    // With zero wait states the access executes in the accept cycle, before
    // the latches are loaded, so the live bus feeds the datapath in IDLE.
    assign cur_we     = (state_q == ST_IDLE) ? dmem.req_we_in     : we_q;
    assign cur_addr   = (state_q == ST_IDLE) ? dmem.req_addr_in   : addr_q;
    assign cur_funct3 = (state_q == ST_IDLE) ? dmem.req_funct3_in : funct3_q;
    assign cur_wdata  = (state_q == ST_IDLE) ? dmem.req_wdata_in  : wdata_q;

    assign offset    = cur_addr - BASE_ADDR;
    assign range_err = (offset >= SPAN);
    assign idx       = offset[IDX_W+1:2];
    assign rword     = mem[idx];
    assign acc_err   = range_err || lane_bad;
    assign rdata_d   = (acc_err || cur_we) ? 32'h0 : ldata;

    // Reset always wins over the execute cycle so an aborted store never lands
    assign exec = !rst_in &&
                  (((LATENCY == 0) && accept) ||
                   ((state_q == ST_WAIT) && (cnt_q == 4'd0)));

    dmem_lane_align u_align (
        .we_i     (cur_we),
        .funct3_i (cur_funct3),
        .lane_i   (cur_addr[1:0]),
        .wdata_i  (cur_wdata),
        .rword_i  (rword),
        .be_o     (be),
        .sdata_o  (sdata),
        .ldata_o  (ldata),
        .bad_o    (lane_bad)
    );

    // Request FSM: accept, count wait states, register response, hold until taken
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        we_q     <= dmem.req_we_in;
                        addr_q   <= dmem.req_addr_in;
                        funct3_q <= dmem.req_funct3_in;
                        wdata_q  <= dmem.req_wdata_in;
                        if (LATENCY == 0) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rdata_d;
                            rsp_err_q   <= acc_err;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= LOAD_CNT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata_d;
                        rsp_err_q   <= acc_err;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (dmem.rsp_ready_in) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Byte-enable RAM write on a legal store in the execute cycle
    always_ff @(posedge clk_in) begin
        if (exec && cur_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= sdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=1 instance (a) and one
// LATENCY=0 instance (b) sharing the request drivers, selected by sel.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int LAT_A = 1;
    localparam int LAT_B = 0;

    logic clk;
    logic rst;
    logic sel;
    logic        r_valid;
    logic        r_we;
    logic [31:0] r_addr;
    logic [2:0]  r_f3;
    logic [31:0] r_wdata;
    logic        r_rsp_ready;

    int total;
    int bad;

    dmem_responder_if ifa ();
    dmem_responder_if ifb ();

    assign ifa.req_valid_in  = r_valid & ~sel;
    assign ifa.req_we_in     = r_we;
    assign ifa.req_addr_in   = r_addr;
    assign ifa.req_funct3_in = r_f3;
    assign ifa.req_wdata_in  = r_wdata;
    assign ifa.rsp_ready_in  = r_rsp_ready;

    assign ifb.req_valid_in  = r_valid & sel;
    assign ifb.req_we_in     = r_we;
    assign ifb.req_addr_in   = r_addr;
    assign ifb.req_funct3_in = r_f3;
    assign ifb.req_wdata_in  = r_wdata;
    assign ifb.rsp_ready_in  = r_rsp_ready;

    logic        rdy_m;
    logic        vld_m;
    logic [31:0] rdata_m;
    logic        err_m;
    assign rdy_m   = sel ? ifb.req_ready_out : ifa.req_ready_out;
    assign vld_m   = sel ? ifb.rsp_valid_out : ifa.rsp_valid_out;
    assign rdata_m = sel ? ifb.rsp_rdata_out : ifa.rsp_rdata_out;
    assign err_m   = sel ? ifb.rsp_err_out   : ifa.rsp_err_out;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT_A), .BASE_ADDR(32'h0)) dut_a (
        .clk_in (clk),
        .rst_in (rst),
        .dmem   (ifa.slave)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT_B), .BASE_ADDR(32'h0)) dut_b (
        .clk_in (clk),
        .rst_in (rst),
        .dmem   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete transaction; called right after a falling edge.
    task automatic access(input logic s, input logic we, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int cyc);
        int guard;
        sel = s; r_we = we; r_addr = addr; r_f3 = f3; r_wdata = wd;
        r_valid = 1'b1;
        guard = 0;
        while (!rdy_m && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        r_valid = 1'b0;
        cyc = 1;
        while (!vld_m && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        rd = rdata_m;
        er = err_m;
        if (!vld_m) begin
            total++; bad++;
            $display("FAIL rsp_timeout addr=%h got_valid=%b need=1", addr, vld_m);
        end
        r_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (ifa.req_ready_out !== 1'b0) begin bad++; $display("FAIL rst_ready_a got=%b need=0", ifa.req_ready_out); end
        total++; if (ifb.req_ready_out !== 1'b0) begin bad++; $display("FAIL rst_ready_b got=%b need=0", ifb.req_ready_out); end
        total++; if (ifa.rsp_valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b need=0", ifa.rsp_valid_out); end
        total++; if (ifa.rsp_rdata_out !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h need=0", ifa.rsp_rdata_out); end
        total++; if (ifa.rsp_err_out !== 1'b0) begin bad++; $display("FAIL rst_err got=%b need=0", ifa.rsp_err_out); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (ifa.req_ready_out !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b need=1", ifa.req_ready_out); end
    endtask

    // SW/LW word round trip and byte store/loads on the chosen instance
    task automatic test_word_byte(input logic s, input int lat);
        logic [31:0] rd;
        logic er;
        int cyc;
        access(s, 1'b1, 32'h10, FUNCT3_SW, 32'hDEADBEEF, rd, er, cyc);
        total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL sw_rsp s=%b got=%h/%b need=0/0", s, rd, er); end
        total++; if (cyc !== lat + 1) begin bad++; $display("FAIL sw_latency s=%b got=%0d need=%0d", s, cyc, lat + 1); end
        access(s, 1'b0, 32'h10, FUNCT3_LW, 32'h0, rd, er, cyc);
        total++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("FAIL lw_word s=%b got=%h/%b need=deadbeef/0", s, rd, er); end
        total++; if (cyc !== lat + 1) begin bad++; $display("FAIL lw_latency s=%b got=%0d need=%0d", s, cyc, lat + 1); end
        access(s, 1'b1, 32'h13, FUNCT3_SB, 32'h00000080, rd, er, cyc);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL sb_err s=%b got=%b need=0", s, er); end
        access(s, 1'b0, 32'h13, FUNCT3_LB, 32'h0, rd, er, cyc);
        total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_sext s=%b got=%h need=ffffff80", s, rd); end
        access(s, 1'b0, 32'h13, FUNCT3_LBU, 32'h0, rd, er, cyc);
        total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL lbu_zext s=%b got=%h need=00000080", s, rd); end
        access(s, 1'b0, 32'h10, FUNCT3_LW, 32'h0, rd, er, cyc);
        total++; if (rd !== 32'h80ADBEEF) begin bad++; $display("FAIL lw_after_sb s=%b got=%h need=80adbeef", s, rd); end
    endtask

    task automatic test_half_misalign();
        logic [31:0] rd;
        logic er;
        int cyc;
        access(1'b0, 1'b1, 32'h12, FUNCT3_SH, 32'h00001234, rd, er, cyc);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL sh_err got=%b need=0", er); end
        access(1'b0, 1'b0, 32'h12, FUNCT3_LH, 32'h0, rd, er, cyc);
        total++; if (rd !== 32'h00001234 || er !== 1'b0) begin bad++; $display("FAIL lh_half got=%h/%b need=00001234/0", rd, er); end
        access(1'b0, 1'b0, 32'h10, FUNCT3_LH, 32'h0, rd, er, cyc);
        total++; if (rd !== 32'hFFFFBEEF) begin bad++; $display("FAIL lh_sext got=%h need=ffffbeef", rd); end
        access(1'b0, 1'b0, 32'h10, FUNCT3_LHU, 32'h0, rd, er, cyc);
        total++; if (rd !== 32'h0000BEEF) begin bad++; $display("FAIL lhu_zext got=%h need=0000beef", rd); end
        access(1'b0, 1'b0, 32'h11, FUNCT3_LW, 32'h0, rd, er, cyc);
        total++; if (rd !== 32'h0 || er !== 1'b1) begin bad++; $display("FAIL lw_misalign got=%h/%b need=0/1", rd, er); end
        total++; if (cyc !== LAT_A + 1) begin bad++; $display("FAIL err_latency got=%0d need=%0d", cyc, LAT_A + 1); end
        access(1'b0, 1'b1, 32'h11, FUNCT3_SH, 32'h0000AAAA, rd, er, cyc);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL sh_misalign got=%b need=1", er); end
        access(1'b0, 1'b0, 32'h10, FUNCT3_LW, 32'h0, rd, er, cyc);
        total++; if (rd !== 32'h1234BEEF) begin bad++; $display("FAIL word_unchanged got=%h need=1234beef", rd); end
    endtask

    task automatic test_range_illegal();
        logic [31:0] rd;
        logic er;
        int cyc;
        access(1'b0, 1'b0, 32'h1000, FUNCT3_LW, 32'h0, rd, er, cyc);
        total++; if (rd !== 32'h0 || er !== 1'b1) begin bad++; $display("FAIL lw_range got=%h/%b need=0/1", rd, er); end
        access(1'b0, 1'b0, 32'hFFFF_FFFC, FUNCT3_LW, 32'h0, rd, er, cyc);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL lw_range_wrap got=%b need=1", er); end
        access(1'b0, 1'b0, 32'h10, 3'b011, 32'h0, rd, er, cyc);
        total++; if (rd !== 32'h0 || er !== 1'b1) begin bad++; $display("FAIL load_f3_illegal got=%h/%b need=0/1", rd, er); end
        access(1'b0, 1'b1, 32'h10, 3'b100, 32'h55555555, rd, er, cyc);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL store_f3_illegal got=%b need=1", er); end
        access(1'b0, 1'b0, 32'hFFC, FUNCT3_LW, 32'h0, rd, er, cyc);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL lw_last_word_err got=%b need=0", er); end
        access(1'b0, 1'b0, 32'h10, FUNCT3_LW, 32'h0, rd, er, cyc);
        total++; if (rd !== 32'h1234BEEF) begin bad++; $display("FAIL illegal_no_write got=%h need=1234beef", rd); end
    endtask

    task automatic test_backpressure();
        int cyc;
        sel = 1'b0; r_we = 1'b0; r_addr = 32'h10; r_f3 = FUNCT3_LW; r_wdata = 32'h0;
        r_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_valid = 1'b0;
        cyc = 1;
        while (!vld_m && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (vld_m !== 1'b1 || rdata_m !== 32'h1234BEEF || err_m !== 1'b0 || rdy_m !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got v=%b d=%h e=%b r=%b need v=1 d=1234beef e=0 r=0",
                         i, vld_m, rdata_m, err_m, rdy_m);
            end
            @(negedge clk);
        end
        r_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_rsp_ready = 1'b0;
        total++; if (vld_m !== 1'b0 || rdy_m !== 1'b1) begin bad++; $display("FAIL bp_release got v=%b r=%b need v=0 r=1", vld_m, rdy_m); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        logic er;
        int cyc;
        access(1'b0, 1'b1, 32'h20, FUNCT3_SW, 32'h11111111, rd, er, cyc);
        sel = 1'b0; r_we = 1'b1; r_addr = 32'h20; r_f3 = FUNCT3_SW; r_wdata = 32'h22222222;
        r_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++; if (ifa.rsp_valid_out !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b need=0", ifa.rsp_valid_out); end
        @(negedge clk);
        access(1'b0, 1'b0, 32'h20, FUNCT3_LW, 32'h0, rd, er, cyc);
        total++; if (rd !== 32'h11111111) begin bad++; $display("FAIL abort_no_write got=%h need=11111111", rd); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        sel = 1'b0;
        r_valid = 1'b0;
        r_we = 1'b0;
        r_addr = 32'h0;
        r_f3 = 3'b000;
        r_wdata = 32'h0;
        r_rsp_ready = 1'b0;
        test_reset();
        test_word_byte(1'b0, LAT_A);
        test_half_misalign();
        test_range_illegal();
        test_backpressure();
        test_reset_abort();
        test_word_byte(1'b1, LAT_B);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
